// File: rtl/ahb_dma_ch_rr_arb.sv
// ---------------------------------------------------------------------------
// ahb_dma_ch_rr_arb
// Channel arbiter that sits after the DMA priority encoder. It picks one
// requesting channel whose programmed priority equals the encoder's registered
// highest priority. Equal-priority channels are served round-robin. The grant
// is held through a req/ack/done handshake with the transfer engine, and the
// rotation pointer moves only when a transfer completes.
//
// Ports
//   clk, rst_n  : clock and asynchronous active-low reset
//   valid       : per-channel request (enabled and pending)
//   pri_ch      : packed per-channel priority, channel k at [3k+2:3k]
//   pri_out     : registered highest valid priority from the encoder
//   de_ack      : engine accepted the granted channel (1-cycle pulse)
//   de_done     : engine finished the granted transfer (1-cycle pulse)
//   ch_req      : request to the engine; ch_sel is valid while high
//   ch_sel      : granted channel index
//   ch_gnt      : one-hot grant, zero when no grant is held
//   arb_busy    : high in every state except IDLE
// ---------------------------------------------------------------------------
module ahb_dma_ch_rr_arb #(
  parameter logic [1:0] PRI_SEL        = 2'd2,
  parameter int         CHANNEL_NUMBER = 12,
  parameter int         CH_W           = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNEL_NUMBER-1:0]   valid,
  input  logic [3*CHANNEL_NUMBER-1:0] pri_ch,
  input  logic [2:0]                  pri_out,
  input  logic                        de_ack,
  input  logic                        de_done,
  output logic                        ch_req,
  output logic [CH_W-1:0]             ch_sel,
  output logic [CHANNEL_NUMBER-1:0]   ch_gnt,
  output logic                        arb_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    ARB    = 3'd2,
    REQ    = 3'd3,
    BUSY   = 3'd4
  } state_t;

  // Priority bits that are significant for the configured encoder width.
  localparam logic [2:0] PRI_MASK = (PRI_SEL == 2'd0) ? 3'b001 :
                                    (PRI_SEL == 2'd1) ? 3'b011 : 3'b111;
  // Reset pointer makes channel 0 the first one searched.
  localparam logic [CH_W-1:0] LAST_RST = CH_W'(CHANNEL_NUMBER - 1);

  state_t                      state_r, state_nxt_s;
  logic [CH_W-1:0]             last_r, last_nxt_s;
  logic                        ch_req_r, ch_req_nxt_s;
  logic [CH_W-1:0]             ch_sel_r, ch_sel_nxt_s;
  logic [CHANNEL_NUMBER-1:0]   ch_gnt_r, ch_gnt_nxt_s;
  logic                        arb_busy_r, arb_busy_nxt_s;
  logic [CHANNEL_NUMBER-1:0]   match_s;
  logic                        hit_s;
  logic [CH_W-1:0]             hit_idx_s;
  logic [CH_W-1:0]             idx_w_s;
  int                          idx_s;

  assign ch_req   = ch_req_r;
  assign ch_sel   = ch_sel_r;
  assign ch_gnt   = ch_gnt_r;
  assign arb_busy = arb_busy_r;

  // Channels that request at exactly the encoder's current priority.
  always_comb begin
    match_s = '0;
    for (int k = 0; k < CHANNEL_NUMBER; k++) begin
      match_s[k] = valid[k] && ((pri_ch[3*k +: 3] & PRI_MASK) == pri_out);
    end
  end

  // Round-robin search: first match at or after last+1, wrapping to 0.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    idx_s     = 0;
    idx_w_s   = '0;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      idx_s = int'(last_r) + 32'sd1 + i;
      // last_r never exceeds CHANNEL_NUMBER-1, so one wrap is sufficient
      if (idx_s >= CHANNEL_NUMBER) begin
        idx_s = idx_s - CHANNEL_NUMBER;
      end else begin
        idx_s = idx_s;
      end
      idx_w_s = CH_W'(idx_s);
      if (!hit_s && match_s[idx_w_s]) begin
        hit_s     = 1'b1;
        hit_idx_s = idx_w_s;
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (|valid) state_nxt_s = SETTLE;
        else        state_nxt_s = IDLE;
      end
      SETTLE: state_nxt_s = ARB;
      ARB: begin
        if (hit_s) state_nxt_s = REQ;
        else       state_nxt_s = IDLE;
      end
      REQ: begin
        // ack wins over a simultaneous request withdrawal
        if (de_ack)                 state_nxt_s = BUSY;
        else if (!valid[ch_sel_r])  state_nxt_s = IDLE;
        else                        state_nxt_s = REQ;
      end
      BUSY: begin
        if (de_done) state_nxt_s = IDLE;
        else         state_nxt_s = BUSY;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and the rotation pointer.
  always_comb begin
    ch_req_nxt_s   = ch_req_r;
    ch_sel_nxt_s   = ch_sel_r;
    ch_gnt_nxt_s   = ch_gnt_r;
    last_nxt_s     = last_r;
    arb_busy_nxt_s = (state_nxt_s != IDLE);
    case (state_r)
      ARB: begin
        if (hit_s) begin
          ch_req_nxt_s = 1'b1;
          ch_sel_nxt_s = hit_idx_s;
          ch_gnt_nxt_s = {{(CHANNEL_NUMBER-1){1'b0}}, 1'b1} << hit_idx_s;
        end else begin
          ch_req_nxt_s = ch_req_r;
        end
      end
      REQ: begin
        if (de_ack) begin
          ch_req_nxt_s = 1'b0;
        end else if (!valid[ch_sel_r]) begin
          // aborted grant: pointer stays so the channel is not skipped
          ch_req_nxt_s = 1'b0;
          ch_gnt_nxt_s = '0;
        end else begin
          ch_req_nxt_s = 1'b1;
        end
      end
      BUSY: begin
        if (de_done) begin
          ch_gnt_nxt_s = '0;
          last_nxt_s   = ch_sel_r;
        end else begin
          ch_gnt_nxt_s = ch_gnt_r;
        end
      end
      default: begin
        ch_req_nxt_s = ch_req_r;
      end
    endcase
  end

  // Output and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_req_r   <= 1'b0;
      ch_sel_r   <= '0;
      ch_gnt_r   <= '0;
      arb_busy_r <= 1'b0;
      last_r     <= LAST_RST;
    end else begin
      ch_req_r   <= ch_req_nxt_s;
      ch_sel_r   <= ch_sel_nxt_s;
      ch_gnt_r   <= ch_gnt_nxt_s;
      arb_busy_r <= arb_busy_nxt_s;
      last_r     <= last_nxt_s;
    end
  end

endmodule
